// File: rtl/csa_accum_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator.
package csa_accum_pkg;

  typedef enum logic [1:0] {
    StAccum,
    StResolve,
    StOut
  } state_e;

  function automatic int unsigned num_chunks(input int unsigned width,
                                             input int unsigned chunk_width);
    return width / chunk_width;
  endfunction

  // A counter is at least one bit wide, even when there is a single chunk.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csa_chunk_adder.sv
// Combinational ChunkWidth-bit adder with carry in and carry out.
module csa_chunk_adder #(
  parameter int unsigned ChunkWidth = 8
) (
  input  logic [ChunkWidth-1:0] a_i,
  input  logic [ChunkWidth-1:0] b_i,
  input  logic                  ci_i,
  output logic [ChunkWidth-1:0] sum_o,
  output logic                  co_o
);

  always_comb begin
    {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{ChunkWidth{1'b0}}, ci_i};
  end

endmodule

// File: rtl/csa_accum.sv
// Carry-save multi-operand accumulator with a chunked multi-cycle resolve stage.
// Define CSA_ACCUM_OVF_EN to add the sticky unsigned-overflow output ovf_o.
module csa_accum
  import csa_accum_pkg::*;
#(
  parameter int unsigned Width      = 32,
  parameter int unsigned ChunkWidth = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] op_i,
  input  logic             op_last_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  output logic [Width-1:0] res_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
`ifdef CSA_ACCUM_OVF_EN
  output logic             ovf_o,
`endif
  output logic             busy_o
);

  localparam int unsigned NumChunks = num_chunks(Width, ChunkWidth);
  localparam int unsigned CntW      = cnt_width(NumChunks);
  localparam logic [CntW-1:0] LastChunk = CntW'(NumChunks - 1);

  if ((Width % ChunkWidth) != 0) begin : gen_bad_cfg
    $fatal(1, "csa_accum: Width must be a multiple of ChunkWidth");
  end

  state_e            state_q, state_d;
  logic [Width-1:0]  sreg_q, sreg_d;
  logic [Width-1:0]  creg_q, creg_d;
  logic [Width-1:0]  res_q, res_d;
  logic [CntW-1:0]   k_q, k_d;
  logic              cy_q, cy_d;

  logic [Width-1:0]      maj;
  logic [ChunkWidth-1:0] chunk_a, chunk_b, chunk_sum;
  logic                  chunk_co;
  logic                  acc_fire, resolve_done, res_fire;

  assign maj = (sreg_q & creg_q) | (sreg_q & op_i) | (creg_q & op_i);

  assign chunk_a = sreg_q[32'(k_q) * ChunkWidth +: ChunkWidth];
  assign chunk_b = creg_q[32'(k_q) * ChunkWidth +: ChunkWidth];

  csa_chunk_adder #(
    .ChunkWidth(ChunkWidth)
  ) u_chunk_adder (
    .a_i  (chunk_a),
    .b_i  (chunk_b),
    .ci_i (cy_q),
    .sum_o(chunk_sum),
    .co_o (chunk_co)
  );

  assign acc_fire     = (state_q == StAccum) && op_valid_i;
  assign resolve_done = (state_q == StResolve) && (k_q == LastChunk);
  assign res_fire     = (state_q == StOut) && res_ready_i;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    creg_d  = creg_q;
    res_d   = res_q;
    k_d     = k_q;
    cy_d    = cy_q;
    case (state_q)
      StAccum: begin
        if (acc_fire) begin
          sreg_d = sreg_q ^ creg_q ^ op_i;
          // Shifting the majority left drops its MSB: the total wraps modulo 2^Width.
          creg_d = maj << 1;
          if (op_last_i) begin
            state_d = StResolve;
            k_d     = '0;
            cy_d    = 1'b0;
          end
        end
      end
      StResolve: begin
        res_d[32'(k_q) * ChunkWidth +: ChunkWidth] = chunk_sum;
        cy_d = chunk_co;
        if (resolve_done) begin
          state_d = StOut;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StOut: begin
        if (res_fire) begin
          state_d = StAccum;
          sreg_d  = '0;
          creg_d  = '0;
          k_d     = '0;
          cy_d    = 1'b0;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StAccum;
      sreg_q  <= '0;
      creg_q  <= '0;
      res_q   <= '0;
      k_q     <= '0;
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      creg_q  <= creg_d;
      res_q   <= res_d;
      k_q     <= k_d;
      cy_q    <= cy_d;
    end
  end

`ifdef CSA_ACCUM_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky: any majority bit wrapped off the top, or a carry out of the final chunk.
  always_comb begin
    ovf_d = ovf_q;
    if (acc_fire && maj[Width-1]) ovf_d = 1'b1;
    if (resolve_done && chunk_co) ovf_d = 1'b1;
    if (res_fire) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`endif

  assign op_ready_o  = (state_q == StAccum);
  assign res_valid_o = (state_q == StOut);
  assign busy_o      = (state_q != StAccum);
  assign res_o       = res_q;

endmodule

// File: doc/csa_accum.md
# csa_accum

Sequential multi-operand accumulator that keeps a running total in carry-save form and resolves it to binary on request. Operands arrive one per cycle over a valid/ready stream and are folded into sum/carry registers by a per-bit 3:2 compression row, so accumulation never waits on carry propagation. On the last operand the block turns the carry-save pair into a binary result with a chunked, multi-cycle carry-propagate adder and presents it on a valid/ready output. It sits directly downstream of the compressor arrays as their final carry-propagate stage.

## Interface
- Parameters:
  - `Width`, default 32: operand and result width in bits.
  - `ChunkWidth`, default 8: bits resolved per carry-propagate cycle. `Width % ChunkWidth` must be 0, otherwise elaboration fails (`$fatal`).
- Ports:
  - `clk_i` input 1: clock. Single clock domain; all logic is rising-edge.
  - `rst_ni` input 1: reset, asynchronous, active-low.
  - `op_i` input Width: operand, unsigned.
  - `op_last_i` input 1: marks the final operand of the current accumulation.
  - `op_valid_i` input 1: operand valid.
  - `op_ready_o` output 1: operand accepted when high together with `op_valid_i`.
  - `res_o` output Width: resolved sum, modulo 2^Width.
  - `res_valid_o` output 1: result valid.
  - `res_ready_i` input 1: result consumed.
  - `busy_o` output 1: high in RESOLVE or OUT.
  - `ovf_o` output 1: only when `CSA_ACCUM_OVF_EN` is defined. Unsigned overflow of the accumulation.

## Operation
- State machine: ACCUM, RESOLVE, OUT. Reset state is ACCUM.
- Registers `sreg` and `creg` (each Width bits) hold the running total as `sreg + creg`. Both reset to 0.
- ACCUM:
  - `op_ready_o` = 1.
  - On handshake: `sreg <= sreg ^ creg ^ op_i` and `creg <= {maj(sreg, creg, op_i)[Width-2:0], 1'b0}`. The majority MSB is dropped (wrap).
  - If `op_last_i` is set on the handshake, go to RESOLVE. The last operand is included in the total.
- RESOLVE:
  - Lasts N = Width/ChunkWidth cycles, driven by a chunk counter k = 0..N-1 and a carry register `cy`. `cy` is 0 at entry.
  - Each cycle: `{cy, res[k]} <= sreg[k] + creg[k] + cy`, chunk k being bits `k*ChunkWidth +: ChunkWidth`.
  - After chunk N-1, go to OUT.
  - `op_ready_o` = 0.
- OUT:
  - `res_valid_o` = 1. `res_o` holds steady until the handshake.
  - On `res_valid_o & res_ready_i`: clear `sreg`, `creg`, `cy` and `k` (and `ovf` if present), then go to ACCUM.
- `res_o` is a register. It updates only during RESOLVE and holds its value in ACCUM, OUT and across backpressure.
- Reset values: `op_ready_o` = 1, `res_valid_o` = 0, `res_o` = 0, `busy_o` = 0, `ovf_o` = 0.
- Boundary conditions:
  - Reset asserted mid-RESOLVE or in OUT aborts the operation immediately. The pending result is lost and all outputs take reset values.
  - A single operand with `op_last_i` yields `res_o = op_i`.
  - `op_valid_i` while not in ACCUM is ignored and not consumed.
  - The empty accumulation is impossible: every accumulation contains at least one operand.

## Timing
- Accumulation throughput is one operand per cycle, with no stall between operands.
- Last operand accepted at edge t: RESOLVE occupies cycles t+1..t+N, and `res_valid_o` is high from cycle t+N+1.
- Result handshake at edge u: `op_ready_o` is high in cycle u+1. The next operand can be accepted at edge u+1.
- There is no combinational path from inputs to outputs.

## Configuration
- `CSA_ACCUM_OVF_EN` defined:
  - Adds `ovf_o` and a sticky `ovf` register.
  - `ovf` is set by any dropped majority MSB during ACCUM, or by `cy` = 1 after chunk N-1.
  - The flag is valid in OUT and cleared on the result handshake.
- `CSA_ACCUM_OVF_EN` undefined: no `ovf_o` port and no overflow logic.

## Structure
- Package `csa_accum_pkg`:
  - `state_e` enum (ACCUM, RESOLVE, OUT).
  - Localparam function for N and counter width, `$clog2(N)` with a minimum of 1.
- One sub-module, `csa_chunk_adder`: purely combinational ChunkWidth-bit adder with carry in/out, instantiated once in RESOLVE.

## Test plan
All scenarios use Width=16, ChunkWidth=4, so N=4.
- Operands 0x1234, 0x1111, 0x0001 (last on the third), `res_ready_i` tied high -> `res_o` = 0x2346, `res_valid_o` exactly 5 cycles after the last handshake, `ovf_o` = 0.
- Operands 0xFFFF, 0x0002 (last) -> `res_o` = 0x0001, `ovf_o` = 1.
- Single operand 0xBEEF with last -> `res_o` = 0xBEEF. Then hold `res_ready_i` low for 10 cycles -> `res_o` stays stable, `op_ready_o` = 0, and `op_valid_i` pulses are not consumed.
- 256 back-to-back 0x00FF operands -> `res_o` = 0xFF00, `ovf_o` = 0, with no idle cycles between accepts.
- Assert `rst_ni` low during the 2nd RESOLVE cycle -> all outputs at reset values. The next accumulation 0x0003, 0x0004 (last) -> 0x0007, confirming no stale carry.
